// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage that sits directly behind the PC generator. It takes
//   the current PC and issues one request at a time to instruction memory over a
//   valid/ready handshake. The 32-bit response is captured into the IF/ID output
//   register. The block tells the PC generator when to hold the PC, and it drops
//   in-flight and held work when ID/EX redirects the pipeline (flush).
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   pc_i              current PC from the PC generator
//   flush_i           redirect from ID/EX; kills the in-flight fetch and the held output
//   id_ready_i        ID accepts if_valid_o this cycle
//   imem_req_*        request channel to instruction memory (valid/ready, address)
//   imem_resp_*       response channel (valid, data, access-fault flag)
//   fetch_stall_o     1: the PC generator must hold pc_i
//   if_valid_o        IF/ID register holds a valid instruction
//   if_pc_o           PC of the held instruction
//   if_inst_o         held instruction (NOP when the fetch trapped)
//   if_exc_o          00 none, 01 misaligned fetch, 10 access fault
// -----------------------------------------------------------------------------
module if_fetch #(
   parameter int ADDR_W      = 64,
   parameter int INST_W      = 32,
   parameter int ALIGN_CHECK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              flush_i,
   input  logic              id_ready_i,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   input  logic              imem_resp_err,
   output logic              fetch_stall_o,
   output logic              if_valid_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0] if_inst_o,
   output logic [1:0]        if_exc_o
);

   localparam logic [INST_W-1:0] NOP_INST     = INST_W'(32'h0000_0013);
   localparam logic [1:0]        EXC_NONE     = 2'b00;
   localparam logic [1:0]        EXC_MISALIGN = 2'b01;
   localparam logic [1:0]        EXC_FAULT    = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,   // nothing pending, output empty
      S_WAIT = 2'd1,   // request accepted, response pending
      S_HOLD = 2'd2,   // output valid, ID has not taken it yet
      S_DROP = 2'd3    // flushed while pending: discard the next response
   } state_t;

   state_t state_reg, state_next;

   logic [ADDR_W-1:0] pc_q_reg;
   logic              if_valid_reg;
   logic [ADDR_W-1:0] if_pc_reg;
   logic [INST_W-1:0] if_inst_reg;
   logic [1:0]        if_exc_reg;

   logic misaligned;
   logic can_issue;
   logic issue;
   logic trap;
   logic accept;

   // Misalignment trapping can be compiled out; memory then sees the raw PC.
   generate
      if (ALIGN_CHECK != 0) begin : g_align_check
         assign misaligned = (pc_i[1:0] != 2'b00);
      end else begin : g_no_align_check
         assign misaligned = 1'b0;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // Output / handshake decode
   // ---------------------------------------------------------------------
   always_comb begin
      // A new fetch can start from an empty stage, or from a full stage in
      // the very cycle ID takes the held instruction.
      can_issue      = (state_reg == S_IDLE) || ((state_reg == S_HOLD) && id_ready_i);
      issue          = can_issue && !flush_i && !rst;
      // A misaligned PC never reaches memory; it completes locally as a trap.
      trap           = issue && misaligned;
      imem_req_valid = issue && !misaligned;
      accept         = imem_req_valid && imem_req_ready;
      // The PC is consumed whenever the fetch for it has been started.
      fetch_stall_o  = !(accept || trap);
   end

   assign imem_req_addr = pc_i;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      if (flush_i) begin
         unique case (state_reg)
            S_IDLE, S_HOLD: state_next = S_IDLE;
            // A pending response must still be absorbed before new requests.
            S_WAIT, S_DROP: state_next = imem_resp_valid ? S_IDLE : S_DROP;
            default:        state_next = S_IDLE;
         endcase
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  state_next = S_WAIT;
               end else if (trap) begin
                  state_next = S_HOLD;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  state_next = S_HOLD;
               end
            end
            S_HOLD: begin
               if (id_ready_i) begin
                  if (accept) begin
                     state_next = S_WAIT;
                  end else if (trap) begin
                     state_next = S_HOLD;
                  end else begin
                     state_next = S_IDLE;
                  end
               end
            end
            S_DROP: begin
               if (imem_resp_valid) begin
                  state_next = S_IDLE;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Request PC and IF/ID output register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q_reg <= '0;
      end else if (accept) begin
         pc_q_reg <= pc_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_valid_reg <= 1'b0;
         if_pc_reg    <= '0;
         if_inst_reg  <= '0;
         if_exc_reg   <= EXC_NONE;
      end else if (flush_i) begin
         if_valid_reg <= 1'b0;
      end else if (trap) begin
         if_valid_reg <= 1'b1;
         if_pc_reg    <= pc_i;
         if_inst_reg  <= NOP_INST;
         if_exc_reg   <= EXC_MISALIGN;
      end else if ((state_reg == S_WAIT) && imem_resp_valid) begin
         if_valid_reg <= 1'b1;
         if_pc_reg    <= pc_q_reg;
         if_inst_reg  <= imem_resp_err ? NOP_INST : imem_resp_data;
         if_exc_reg   <= imem_resp_err ? EXC_FAULT : EXC_NONE;
      end else if ((state_reg == S_HOLD) && id_ready_i) begin
         // ID took the instruction; if a new request was accepted on this
         // edge the stage is now waiting, otherwise it is empty.
         if_valid_reg <= 1'b0;
      end
   end

   assign if_valid_o = if_valid_reg;
   assign if_pc_o    = if_pc_reg;
   assign if_inst_o  = if_inst_reg;
   assign if_exc_o   = if_exc_reg;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
//   Self-checking bench for if_fetch: directed scenarios for reset, basic fetch,
//   ID back-pressure, flushes, misaligned PCs, access faults, reset mid-fetch,
//   plus a randomized run against a stream-level reference model (every PC the
//   stage consumes must reach ID in order with the right contents, unless a
//   flush kills it).
// -----------------------------------------------------------------------------
module tb_if_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc_i;
   logic        flush_i;
   logic        id_ready_i;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;
   logic        fetch_stall_o;
   logic        if_valid_o;
   logic [63:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic [1:0]  if_exc_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   if_fetch #(.ADDR_W(64), .INST_W(32), .ALIGN_CHECK(1)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc_i            (pc_i),
      .flush_i         (flush_i),
      .id_ready_i      (id_ready_i),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err),
      .fetch_stall_o   (fetch_stall_o),
      .if_valid_o      (if_valid_o),
      .if_pc_o         (if_pc_o),
      .if_inst_o       (if_inst_o),
      .if_exc_o        (if_exc_o)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory contents used by the randomized run.
   function automatic logic [31:0] mem_data(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   function automatic logic mem_err(input logic [63:0] a);
      return (a[5:2] == 4'd7);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush_i = 1'b0; id_ready_i = 1'b0; imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_err = 1'b0; imem_resp_data = '0; pc_i = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush_i = 1'b0; id_ready_i = 1'b1; imem_req_ready = 1'b1;
      imem_resp_valid = 1'b0; imem_resp_err = 1'b0; imem_resp_data = '0;
      pc_i = 64'h8000_0000;
      tick();
      tick();
      settle();
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_if_valid: got %b want 0", if_valid_o); end
      n_cmp++; if (if_pc_o !== 64'h0) begin n_bad++; $display("FAIL reset_if_pc: got %h want 0", if_pc_o); end
      n_cmp++; if (if_inst_o !== 32'h0) begin n_bad++; $display("FAIL reset_if_inst: got %h want 0", if_inst_o); end
      n_cmp++; if (if_exc_o !== 2'b00) begin n_bad++; $display("FAIL reset_if_exc: got %b want 00", if_exc_o); end
      n_cmp++; if (fetch_stall_o !== 1'b1) begin n_bad++; $display("FAIL reset_stall: got %b want 1", fetch_stall_o); end
      $display("test_reset done");
      rst = 1'b0;
   endtask

   // First fetch with 1-cycle memory, then ID back-pressure, then back-to-back issue.
   task automatic test_basic_and_hold();
      do_reset();
      pc_i = 64'h8000_0000; imem_req_ready = 1'b1; id_ready_i = 1'b0;
      settle();
      n_cmp++; if ({imem_req_valid, imem_req_addr, fetch_stall_o} !== {1'b1, 64'h8000_0000, 1'b0}) begin n_bad++; $display("FAIL basic_req_cyc0: got v=%b a=%h st=%b want v=1 a=80000000 st=0", imem_req_valid, imem_req_addr, fetch_stall_o); end
      tick();
      pc_i = 64'h8000_0004; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
      settle();
      n_cmp++; if ({imem_req_valid, fetch_stall_o, if_valid_o} !== 3'b010) begin n_bad++; $display("FAIL basic_wait_cyc1: got req=%b st=%b val=%b want 0 1 0", imem_req_valid, fetch_stall_o, if_valid_o); end
      tick();
      imem_resp_valid = 1'b0;
      settle();
      n_cmp++; if ({if_valid_o, if_pc_o, if_inst_o, if_exc_o} !== {1'b1, 64'h8000_0000, 32'h0050_0093, 2'b00}) begin n_bad++; $display("FAIL basic_out_cyc2: got v=%b pc=%h inst=%h exc=%b", if_valid_o, if_pc_o, if_inst_o, if_exc_o); end
      for (int i = 0; i < 5; i++) begin
         tick();
         settle();
         n_cmp++; if ({if_valid_o, if_pc_o, if_inst_o, if_exc_o, imem_req_valid, fetch_stall_o} !== {1'b1, 64'h8000_0000, 32'h0050_0093, 2'b00, 1'b0, 1'b1}) begin n_bad++; $display("FAIL hold_stable[%0d]: got v=%b pc=%h inst=%h exc=%b req=%b st=%b", i, if_valid_o, if_pc_o, if_inst_o, if_exc_o, imem_req_valid, fetch_stall_o); end
      end
      id_ready_i = 1'b1;
      settle();
      n_cmp++; if ({imem_req_valid, imem_req_addr, fetch_stall_o} !== {1'b1, 64'h8000_0004, 1'b0}) begin n_bad++; $display("FAIL b2b_issue: got v=%b a=%h st=%b want 1 80000004 0", imem_req_valid, imem_req_addr, fetch_stall_o); end
      tick();
      id_ready_i = 1'b0; pc_i = 64'h8000_0008; imem_resp_valid = 1'b1; imem_resp_data = 32'h00A0_0113;
      settle();
      n_cmp++; if ({if_valid_o, imem_req_valid} !== 2'b00) begin n_bad++; $display("FAIL b2b_cleared: got val=%b req=%b want 0 0", if_valid_o, imem_req_valid); end
      tick();
      imem_resp_valid = 1'b0;
      settle();
      n_cmp++; if ({if_valid_o, if_pc_o, if_inst_o, if_exc_o} !== {1'b1, 64'h8000_0004, 32'h00A0_0113, 2'b00}) begin n_bad++; $display("FAIL b2b_out: got v=%b pc=%h inst=%h exc=%b", if_valid_o, if_pc_o, if_inst_o, if_exc_o); end
      $display("test_basic_and_hold done");
   endtask

   // Flush while waiting; the late response must be swallowed.
   task automatic test_flush_wait();
      do_reset();
      pc_i = 64'h8000_0000; imem_req_ready = 1'b1; id_ready_i = 1'b1;
      settle();
      tick();
      flush_i = 1'b1;
      settle();
      n_cmp++; if ({imem_req_valid, fetch_stall_o} !== 2'b01) begin n_bad++; $display("FAIL flushw_flush_cycle: got req=%b st=%b want 0 1", imem_req_valid, fetch_stall_o); end
      tick();
      flush_i = 1'b0; pc_i = 64'h8000_0100;
      for (int i = 0; i < 2; i++) begin
         settle();
         n_cmp++; if ({if_valid_o, imem_req_valid} !== 2'b00) begin n_bad++; $display("FAIL flushw_drop[%0d]: got val=%b req=%b want 0 0", i, if_valid_o, imem_req_valid); end
         tick();
      end
      imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
      settle();
      n_cmp++; if ({if_valid_o, imem_req_valid} !== 2'b00) begin n_bad++; $display("FAIL flushw_resp_cycle: got val=%b req=%b want 0 0", if_valid_o, imem_req_valid); end
      tick();
      imem_resp_valid = 1'b0;
      settle();
      n_cmp++; if ({if_valid_o, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 64'h8000_0100}) begin n_bad++; $display("FAIL flushw_new_req: got val=%b req=%b a=%h want 0 1 80000100", if_valid_o, imem_req_valid, imem_req_addr); end
      tick();
      imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
      tick();
      imem_resp_valid = 1'b0; id_ready_i = 1'b0;
      settle();
      n_cmp++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 64'h8000_0100, 32'h1111_1111}) begin n_bad++; $display("FAIL flushw_after: got v=%b pc=%h inst=%h", if_valid_o, if_pc_o, if_inst_o); end
      $display("test_flush_wait done");
   endtask

   // Flush in the same cycle as the response: back to IDLE, nothing shown to ID.
   task automatic test_flush_resp();
      do_reset();
      pc_i = 64'h8000_0000; imem_req_ready = 1'b1; id_ready_i = 1'b1;
      settle();
      tick();
      imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0093; flush_i = 1'b1;
      tick();
      imem_resp_valid = 1'b0; flush_i = 1'b0;
      settle();
      n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL flushr_valid: got %b want 0", if_valid_o); end
      n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL flushr_idle_issue: got req=%b want 1", imem_req_valid); end
      tick();
      settle();
      n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL flushr_valid_later: got %b want 0", if_valid_o); end
      $display("test_flush_resp done");
   endtask

   task automatic test_misaligned();
      do_reset();
      pc_i = 64'h8000_0002; imem_req_ready = 1'b1; id_ready_i = 1'b0;
      settle();
      n_cmp++; if ({imem_req_valid, fetch_stall_o} !== 2'b00) begin n_bad++; $display("FAIL mis_issue: got req=%b st=%b want 0 0", imem_req_valid, fetch_stall_o); end
      tick();
      pc_i = 64'h8000_0004;
      settle();
      n_cmp++; if ({if_valid_o, if_pc_o, if_inst_o, if_exc_o} !== {1'b1, 64'h8000_0002, NOP, 2'b01}) begin n_bad++; $display("FAIL mis_out: got v=%b pc=%h inst=%h exc=%b", if_valid_o, if_pc_o, if_inst_o, if_exc_o); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mis_hold_req: got %b want 0", imem_req_valid); end
      $display("test_misaligned done");
   endtask

   // Access fault, then reset asserted while a request is pending.
   task automatic test_err_and_reset();
      do_reset();
      pc_i = 64'h8000_0040; imem_req_ready = 1'b1; id_ready_i = 1'b0;
      settle();
      tick();
      imem_resp_valid = 1'b1; imem_resp_err = 1'b1; imem_resp_data = 32'hCAFE_F00D;
      tick();
      imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
      settle();
      n_cmp++; if ({if_valid_o, if_pc_o, if_inst_o, if_exc_o} !== {1'b1, 64'h8000_0040, NOP, 2'b10}) begin n_bad++; $display("FAIL err_out: got v=%b pc=%h inst=%h exc=%b", if_valid_o, if_pc_o, if_inst_o, if_exc_o); end
      id_ready_i = 1'b1; pc_i = 64'h8000_0044;
      settle();
      tick();
      id_ready_i = 1'b0; rst = 1'b1;
      settle();
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rstw_req_during: got %b want 0", imem_req_valid); end
      tick();
      rst = 1'b0;
      settle();
      n_cmp++; if ({if_valid_o, if_pc_o, if_inst_o, if_exc_o} !== {1'b0, 64'h0, 32'h0, 2'b00}) begin n_bad++; $display("FAIL rstw_out: got v=%b pc=%h inst=%h exc=%b want all 0", if_valid_o, if_pc_o, if_inst_o, if_exc_o); end
      n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rstw_idle_issue: got req=%b want 1", imem_req_valid); end
      $display("test_err_and_reset done");
   endtask

   // Random traffic: every consumed PC must reach ID in order unless flushed.
   task automatic test_random();
      logic [63:0] pc;
      logic [63:0] exp_pc[$];
      logic [31:0] exp_inst[$];
      logic [1:0]  exp_exc[$];
      logic [63:0] qpc;
      logic [31:0] qinst;
      logic [1:0]  qexc;
      logic [63:0] maddr;
      bit          pend;
      int          cnt;
      int          delivered;
      do_reset();
      pc = 64'h8000_0000; pend = 1'b0; cnt = 0; maddr = '0; delivered = 0;
      for (int c = 0; c < 3000; c++) begin
         pc_i           = pc;
         id_ready_i     = ($urandom_range(0, 9) < 7);
         flush_i        = ($urandom_range(0, 31) == 0);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         imem_resp_valid = 1'b0; imem_resp_err = 1'b0; imem_resp_data = $urandom;
         if (pend) begin
            if (cnt <= 1) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = mem_data(maddr);
               imem_resp_err   = mem_err(maddr);
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
         settle();
         if (imem_req_valid) begin
            n_cmp++; if (imem_req_addr !== pc_i) begin n_bad++; $display("FAIL rnd_req_addr c=%0d: got %h want %h", c, imem_req_addr, pc_i); end
         end
         if (flush_i) begin
            n_cmp++; if (fetch_stall_o !== 1'b1) begin n_bad++; $display("FAIL rnd_flush_stall c=%0d: got %b want 1", c, fetch_stall_o); end
            exp_pc.delete(); exp_inst.delete(); exp_exc.delete();
            pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
            if ($urandom_range(0, 7) == 0) pc = pc + 64'd2;
         end else begin
            if (if_valid_o && id_ready_i) begin
               n_cmp++;
               if (exp_pc.size() == 0) begin
                  n_bad++; $display("FAIL rnd_unexpected c=%0d: got pc=%h with nothing expected", c, if_pc_o);
               end else begin
                  qpc = exp_pc.pop_front(); qinst = exp_inst.pop_front(); qexc = exp_exc.pop_front();
                  if ({if_pc_o, if_inst_o, if_exc_o} !== {qpc, qinst, qexc}) begin
                     n_bad++; $display("FAIL rnd_deliver c=%0d: got pc=%h inst=%h exc=%b want pc=%h inst=%h exc=%b", c, if_pc_o, if_inst_o, if_exc_o, qpc, qinst, qexc);
                  end else begin
                     $display("deliver c=%0d pc=%h inst=%h exc=%b", c, if_pc_o, if_inst_o, if_exc_o);
                  end
               end
               delivered++;
            end
            if (!fetch_stall_o) begin
               exp_pc.push_back(pc);
               if (pc[1:0] != 2'b00) begin
                  exp_inst.push_back(NOP); exp_exc.push_back(2'b01);
                  pc = {pc[63:2], 2'b00} + 64'd4;
               end else begin
                  if (mem_err(pc)) begin
                     exp_inst.push_back(NOP); exp_exc.push_back(2'b10);
                  end else begin
                     exp_inst.push_back(mem_data(pc)); exp_exc.push_back(2'b00);
                  end
                  pc = (($urandom_range(0, 31) == 0) ? pc + 64'd2 : pc + 64'd4);
               end
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            pend  = 1'b1;
            cnt   = $urandom_range(1, 4);
            maddr = imem_req_addr;
         end
         tick();
      end
      n_cmp++; if (delivered < 100) begin n_bad++; $display("FAIL rnd_progress: got %0d deliveries want at least 100", delivered); end
      $display("test_random done, %0d deliveries", delivered);
   endtask

   initial begin
      test_reset();
      test_basic_and_hold();
      test_flush_wait();
      test_flush_resp();
      test_misaligned();
      test_err_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
